btn_debounce: RTL
=================

Name: btn_debounce

Overview:
- Conditions the raw board push-button before it reaches the LED blink logic.
- Synchronises the asynchronous pin into the clock domain and rejects contact bounce with a counter-qualified state machine.
- Produces a clean level, single-cycle press/release/long-press pulses, and a press-toggled level.
- `btn_toggle` or `btn_level` drives the blink block's `btn_0` input directly.

Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Legal values ≥ 1.
- `HOLD_CYCLES`, default 100000000: cycles after press acceptance before `long_press` fires (1 s at 100 MHz). Legal values ≥ 1.
- `BTN_ACTIVE_LOW`, default 0: 1 means the pin reads 0 when pressed.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `btn_0` in 1: raw asynchronous button pin.
- `btn_level` out 1: debounced pressed level (1 = pressed).
- `press_pulse` out 1: one-cycle strobe on accepted press.
- `release_pulse` out 1: one-cycle strobe on accepted release.
- `long_press` out 1: one-cycle strobe when a press has been held `HOLD_CYCLES`.
- `btn_toggle` out 1: inverts on every accepted press.

Behaviour:
- **Interface:** one clock; reset is synchronous and active-low. Clock port is `clk`, reset port is `rst_n`. Every register is reset only on a rising `clk` edge with `rst_n`=0.
- **Reset values:**
  - All outputs 0.
  - FSM in RELEASED.
  - Both counters 0.
  - Synchroniser flops hold the released pin level (`BTN_ACTIVE_LOW`).
- **Synchroniser:** two flops on `btn_0`. `pressed_s` = sync2 XOR `BTN_ACTIVE_LOW`. No logic reads sync1 or `btn_0` directly.
- **Debounce counter:** width `$clog2(DEBOUNCE_CYCLES+1)`.
- **Hold counter:** width `$clog2(HOLD_CYCLES+1)`; saturates at `HOLD_CYCLES`.
- **FSM states and transitions:**
  - RELEASED: if `pressed_s`=1, go to PRESS_WAIT and clear the debounce counter.
  - PRESS_WAIT:
    - If `pressed_s`=0, return to RELEASED. No pulse.
    - Otherwise, when the counter equals `DEBOUNCE_CYCLES`-1, go to PRESSED, pulse `press_pulse`, set `btn_level`=1, invert `btn_toggle`, clear the hold counter.
    - Otherwise, increment the counter.
  - PRESSED: if `pressed_s`=0, go to RELEASE_WAIT and clear the debounce counter.
  - RELEASE_WAIT:
    - If `pressed_s`=1, return to PRESSED with no pulse; the hold count is kept.
    - When the counter equals `DEBOUNCE_CYCLES`-1, go to RELEASED, pulse `release_pulse`, set `btn_level`=0.
    - Otherwise, increment the counter.
- **Latency:** a clean pin change first sampled at edge E0 asserts `press_pulse` (or `release_pulse`) in the cycle after edge E0+2+`DEBOUNCE_CYCLES`. `btn_level` and `btn_toggle` change on that same edge.
- **Long press:**
  - In PRESSED and RELEASE_WAIT, the hold counter increments each cycle.
  - `long_press` pulses in the cycle the counter reaches `HOLD_CYCLES`.
  - It fires once per accepted press; saturation prevents repeats.
  - If the release is accepted first, there is no `long_press`.
- **Exclusivity:** `press_pulse`, `release_pulse` and `long_press` are registered outputs. `press_pulse` and `release_pulse` are never high in the same cycle. `long_press` never fires in the `press_pulse` cycle, which holds for `HOLD_CYCLES` ≥ 1.
- **Bounce rule:** any glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- **Reset mid-operation:**
  - All state returns to reset values immediately on the reset edge. Pulses in flight are dropped and `btn_toggle` returns to 0.
  - A button still held when `rst_n` deasserts is re-accepted via the normal PRESS_WAIT path, producing a fresh `press_pulse`.
- **Pin held steady:** no pulses while the pin is unchanged, except the single `long_press`.

Test Plan:
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=20, `BTN_ACTIVE_LOW`=0, 10 ns clock.
1. **Reset then idle:** hold `rst_n`=0 for 3 cycles with `btn_0`=0, then release and idle 20 cycles → all outputs 0 throughout.
2. **Clean press:** `btn_0` 0→1 sampled at edge E0 → `press_pulse`=1 for exactly one cycle after edge E0+6. `btn_level` and `btn_toggle` go 1 on that edge. Hold 10 cycles then drop → `release_pulse` one cycle after the drop edge +6, `btn_level`=0, `btn_toggle` stays 1.
3. **Bounce:** `btn_0` pattern 1,0,1,1,0,1 (one cycle each), then steady 1 → no pulse during the bounce. Exactly one `press_pulse` arrives 6 cycles after the final 0→1 sample.
4. **Long press:** press and hold 40 cycles → `press_pulse` once, then `long_press` once exactly 20 cycles later, no repeat. A second press held only 10 cycles → no `long_press`.
5. **Toggle:** three separated clean presses → `btn_toggle` sequence 1, 0, 1, changing only on `press_pulse` cycles.
6. **Reset mid-press:** assert `rst_n`=0 for 1 cycle while `btn_level`=1 and the button is held → outputs 0 on that edge. After release of `rst_n`, `press_pulse` occurs 2+4 cycles later and `btn_toggle`=1.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// single-cycle press/release/long-press strobes and a press-toggled level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned HOLD_CYCLES     = 100000000,
   parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_0,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press,
   output logic btn_toggle
);

   localparam int unsigned DbCntW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HoldCntW = $clog2(HOLD_CYCLES + 1);

   localparam logic [DbCntW-1:0]   DbLast   = DbCntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldCntW-1:0] HoldMax  = HoldCntW'(HOLD_CYCLES);
   localparam logic [HoldCntW-1:0] HoldLast = HoldCntW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      StReleased,
      StPressWait,
      StPressed,
      StReleaseWait
   } state_e;

   state_e              state_q;
   logic [DbCntW-1:0]   db_cnt_q;
   logic [HoldCntW-1:0] hold_cnt_q;
   logic                sync1_q;
   logic                sync2_q;
   logic                pressed_s;

   // Two-flop synchroniser; resets to the released pin level so reset does not look like a press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= BTN_ACTIVE_LOW;
         sync2_q <= BTN_ACTIVE_LOW;
      end else begin
         sync1_q <= btn_0;
         sync2_q <= sync1_q;
      end
   end

   assign pressed_s = sync2_q ^ BTN_ACTIVE_LOW;

   // Debounce FSM with registered level, toggle and one-cycle strobes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StReleased;
         db_cnt_q      <= '0;
         hold_cnt_q    <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         btn_toggle    <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;

         // Hold counter runs while the press is accepted; saturation makes long_press one-shot.
         if ((state_q == StPressed || state_q == StReleaseWait) && hold_cnt_q != HoldMax) begin
            hold_cnt_q <= hold_cnt_q + HoldCntW'(1);
            if (hold_cnt_q == HoldLast) begin
               long_press <= 1'b1;
            end
         end

         case (state_q)
            StReleased: begin
               if (pressed_s) begin
                  state_q  <= StPressWait;
                  db_cnt_q <= '0;
               end
            end
            StPressWait: begin
               if (!pressed_s) begin
                  state_q <= StReleased;
               end else if (db_cnt_q == DbLast) begin
                  state_q     <= StPressed;
                  press_pulse <= 1'b1;
                  btn_level   <= 1'b1;
                  btn_toggle  <= ~btn_toggle;
                  hold_cnt_q  <= '0;
               end else begin
                  db_cnt_q <= db_cnt_q + DbCntW'(1);
               end
            end
            StPressed: begin
               if (!pressed_s) begin
                  state_q  <= StReleaseWait;
                  db_cnt_q <= '0;
               end
            end
            StReleaseWait: begin
               // A bounce back to pressed keeps the hold count running.
               if (pressed_s) begin
                  state_q <= StPressed;
               end else if (db_cnt_q == DbLast) begin
                  state_q       <= StReleased;
                  release_pulse <= 1'b1;
                  btn_level     <= 1'b0;
               end else begin
                  db_cnt_q <= db_cnt_q + DbCntW'(1);
               end
            end
            default: state_q <= StReleased;
         endcase
      end
   end

endmodule
